// File: rtl/cnn_pkg.sv
// Shared widths, accumulator type and saturation limits for the CNN datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int LEN_W_DEF  = 16;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};
endpackage

// File: rtl/cnn_sat_add.sv
// Signed saturating adder: a + b clamped to the acc_t range, with overflow flag.
// Latency: combinational.
// Backpressure: none (pure function).
module cnn_sat_add
    import cnn_pkg::*;
(
    input  acc_t a,
    input  acc_t b,
    output acc_t sum,
    output logic ovf
);
    logic signed [ACC_W_DEF:0] wide;

    // One extra bit catches overflow; clamp toward the sign of the true result.
    always_comb begin
        wide = {a[ACC_W_DEF-1], a} + {b[ACC_W_DEF-1], b};
        ovf  = wide[ACC_W_DEF] != wide[ACC_W_DEF-1];
        sum  = wide[ACC_W_DEF-1:0];
        if (ovf) begin
            sum = wide[ACC_W_DEF] ? ACC_MIN : ACC_MAX;
        end
    end
endmodule

// File: rtl/cnn_dot_acc.sv
// Streaming signed dot product of cfg_len (data, weight) pairs onto a bias, saturated.
// Latency: last beat accepted at cycle t gives out_valid at t+2; one beat per cycle.
// Backpressure: output stall freezes the accumulator; one more beat may enter the product stage.
module cnn_dot_acc
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic        [LEN_W-1:0]  cfg_len,
    input  logic signed [ACC_W-1:0]  in_bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] in_weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_sat
);
    logic [LEN_W-1:0]          cnt;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          len_eff;
    logic                      first;
    logic                      last;
    logic                      in_fire;
    logic                      adv;
    logic                      p_load;
    logic signed [2*DATA_W-1:0] mul;

    logic                      prod_vld;
    logic                      first_q;
    logic                      last_q;
    logic signed [ACC_W-1:0]   prod_q;
    logic signed [ACC_W-1:0]   bias_q;

    logic signed [ACC_W-1:0]   acc_q;
    logic                      sat_q;
    logic signed [ACC_W-1:0]   base;
    acc_t                      sum;
    logic                      ovf;
    logic                      sat_nxt;

    // Stage A moves whenever the output register is free or being drained;
    // stage P may refill as long as its content can move on (or it is empty).
    assign adv      = !out_valid || out_ready;
    assign p_load   = !prod_vld || adv;
    assign in_ready = p_load;
    assign in_fire  = in_valid && in_ready;

    // First beat uses the live cfg_len (0 means 1); later beats use the latched length.
    assign first   = (cnt == '0);
    assign len_eff = first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
    assign last    = (cnt == len_eff - LEN_W'(1));
    assign mul     = in_data * in_weight;

    // Beat counter: latch the vector length on the first beat, wrap on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (in_fire) begin
            if (first) begin
                len_q <= len_eff;
            end
            cnt <= last ? '0 : cnt + LEN_W'(1);
        end
    end

    // Stage P: register the full-precision product with its vector position flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_vld <= 1'b0;
            prod_q   <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            bias_q   <= '0;
        end else if (p_load) begin
            prod_vld <= in_fire;
            if (in_fire) begin
                prod_q  <= {{(ACC_W-2*DATA_W){mul[2*DATA_W-1]}}, mul};
                first_q <= first;
                last_q  <= last;
                bias_q  <= in_bias;
            end
        end
    end

    // A vector restarts from its bias; the sticky flag restarts with it.
    assign base    = first_q ? bias_q : acc_q;
    assign sat_nxt = (sat_q && !first_q) || ovf;

    cnn_sat_add u_sat_add (
        .a   (base),
        .b   (prod_q),
        .sum (sum),
        .ovf (ovf)
    );

    // Stage A and output register: accumulate, publish on the last product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= prod_vld && last_q;
            if (prod_vld) begin
                acc_q <= sum;
                sat_q <= sat_nxt;
                if (last_q) begin
                    out_sum <= sum;
                    out_sat <= sat_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_dot_acc.sv
module tb_cnn_dot_acc;
    localparam int  DATA_W = 8;
    localparam int  ACC_W  = 32;
    localparam int  LEN_W  = 16;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic                     clk;
    logic                     rst_n;
    logic        [LEN_W-1:0]  cfg_len;
    logic signed [ACC_W-1:0]  in_bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] in_weight;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_sum;
    logic                     out_sat;

    cnn_dot_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_bias   (in_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: vectors built from accepted beats with plain saturating arithmetic.
    longint exp_sum[$];
    bit     exp_sat[$];
    int     m_pos = 0;
    int     m_len = 1;
    longint m_acc = 0;
    bit     m_sat = 0;
    int     n_accept = 0;
    int     wait_cyc = 0;

    task automatic mdl_accept(input int d, input int w, input int len, input longint bias);
        n_accept++;
        if (m_pos == 0) begin
            m_len = (len == 0) ? 1 : len;
            m_acc = bias;
            m_sat = 0;
        end
        m_acc = m_acc + longint'(d * w);
        if (m_acc > SMAX) begin m_acc = SMAX; m_sat = 1; end
        if (m_acc < SMIN) begin m_acc = SMIN; m_sat = 1; end
        m_pos++;
        if (m_pos == m_len) begin
            exp_sum.push_back(m_acc);
            exp_sat.push_back(m_sat);
            m_pos = 0;
        end
    endtask

    // Output monitor: every accepted result matches the model in order; stalled output holds.
    int     cyc = 0;
    bit     hold_prev = 0;
    longint hold_sum = 0;
    bit     consec_mode = 0;
    int     n_consec = 0;
    int     last_res_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_sum", longint'(out_sum), hold_sum);
            end
            if (out_valid && out_ready) begin
                if (exp_sum.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("result_sum", longint'(out_sum), exp_sum.pop_front());
                    chk("result_sat", longint'(out_sat), longint'(exp_sat.pop_front()));
                end
                if (consec_mode) begin
                    if (n_consec > 0) chk("b2b_consecutive", longint'(cyc - last_res_cyc), 1);
                    n_consec++;
                end
                last_res_cyc = cyc;
            end
            hold_prev = out_valid && !out_ready;
            hold_sum  = longint'(out_sum);
        end else begin
            hold_prev = 0;
        end
    end

    // Drive one beat (called just after a rising edge); returns just after the accepting edge.
    task automatic send_beat(input int d, input int w, input int len, input longint bias);
        int t;
        t = 0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(d);
        in_weight = DATA_W'(w);
        cfg_len   = LEN_W'(len);
        in_bias   = ACC_W'(bias);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                mdl_accept(d, w, len, bias);
                #1;
                break;
            end
            wait_cyc++;
            t++;
            if (t > 200) begin
                chk("beat_accept_timeout", 0, 1);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input longint es, input longint ef);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, "_valid"}, longint'(out_valid), 1);
        chk({tag, "_sum"}, longint'(out_sum), es);
        chk({tag, "_sat"}, longint'(out_sat), ef);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_sum.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", longint'(exp_sum.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_sum"}, longint'(out_sum), 0);
        chk({tag, "_out_sat"}, longint'(out_sat), 0);
        chk({tag, "_in_ready"}, longint'(in_ready), 1);
    endtask

    task automatic apply_reset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_pos    = 0;
        exp_sum.delete();
        exp_sat.delete();
        check_reset_outputs(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    bit rnd_done = 0;

    initial begin
        int a0;
        int rd, rw, rl;
        longint rb;
        int vd[4];
        int vw[4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        cfg_len   = '0;
        in_bias   = '0;
        out_ready = 1'b1;

        // Reset state
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", longint'(in_ready), 1);
        chk("post_rst_out_valid", longint'(out_valid), 0);
        @(posedge clk); #1;

        // Basic dot product with latency check
        vd = '{1, 2, 3, 4};
        vw = '{5, -6, 7, 8};
        for (int i = 0; i < 4; i++) send_beat(vd[i], vw[i], 4, 10);
        @(negedge clk);
        chk("basic_lat_t1", longint'(out_valid), 0);
        @(negedge clk);
        chk("basic_lat_t2", longint'(out_valid), 1);
        chk("basic_sum", longint'(out_sum), 56);
        chk("basic_sat", longint'(out_sat), 0);
        @(posedge clk); #1;

        // Extremes
        send_beat(-128, -128, 1, 0);
        wait_result("ext_pos", 16384, 0);
        send_beat(-128, 127, 1, -1);
        wait_result("ext_neg", -16257, 0);

        // Saturation then recovery within the same vector
        send_beat(-128, -128, 2, 64'sd2147483548);
        send_beat(1, -1, 2, 0);
        wait_result("sat", 2147483646, 1);
        // A fresh vector clears the sticky flag
        send_beat(2, 3, 1, 0);
        wait_result("sat_clear", 6, 0);
        drain();

        // Back-to-back cfg_len=1
        consec_mode = 1;
        n_consec    = 0;
        wait_cyc    = 0;
        for (int k = 0; k < 8; k++) send_beat(k, 1, 1, 0);
        chk("b2b_stalls", longint'(wait_cyc), 0);
        drain();
        consec_mode = 0;
        chk("b2b_results", longint'(n_consec), 8);

        // Backpressure during cfg_len=1 streaming
        fork
            begin
                for (int k = 0; k < 20; k++) send_beat(k * 3 - 30, 2, 1, k);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                a0 = n_accept;
                repeat (9) @(negedge clk);
                chk("bp_in_ready", longint'(in_ready), 0);
                chk("bp_extra_beats_le1", longint'((n_accept - a0) <= 1), 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-vector: partial sum discarded
        send_beat(9, 9, 4, 1000);
        send_beat(9, 9, 4, 1000);
        apply_reset("rst_mid");
        vd = '{3, -2, 7, 1};
        vw = '{4, 5, -6, 9};
        for (int i = 0; i < 4; i++) send_beat(vd[i], vw[i], 4, 100);
        wait_result("rst_mid_vec", 69, 0);

        // Reset with a result pending at the output
        out_ready = 1'b0;
        send_beat(5, 5, 1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pend_valid", longint'(out_valid), 1);
        @(posedge clk); #1;
        apply_reset("rst_pend");
        out_ready = 1'b1;
        send_beat(-7, 6, 1, 2);
        wait_result("rst_pend_next", -40, 0);
        drain();

        // Randomized traffic with random backpressure and mid-vector config noise
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    rd = int'($urandom_range(0, 255)) - 128;
                    rw = int'($urandom_range(0, 255)) - 128;
                    rl = int'($urandom_range(0, 6));
                    case ($urandom_range(0, 3))
                        0:       rb = SMAX - longint'($urandom_range(0, 40000));
                        1:       rb = SMIN + longint'($urandom_range(0, 40000));
                        2:       rb = longint'(int'($urandom));
                        default: rb = longint'($urandom_range(0, 2000)) - 1000;
                    endcase
                    send_beat(rd, rw, rl, rb);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        drain();

        chk("final_queue_empty", longint'(exp_sum.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
